// File: rtl/div_vec3f_pkg.sv
// Shared fixed-point types, limits and FSM states for the vec3 divider.
// Saturating mode is selected in div_vec3f via DIV_VEC3F_SAT_EN.
package div_vec3f_pkg;

  localparam int FIXED_WIDTH = 32;
  localparam int FIXED_FRAC  = 16;

  typedef logic signed [FIXED_WIDTH-1:0] fixed_t;

  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } vec3_t;

  localparam fixed_t FIXED_MAX =
    {1'b0, {(FIXED_WIDTH-1){1'b1}}};
  localparam fixed_t FIXED_MIN =
    {1'b1, {(FIXED_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIV_X,
    S_DIV_Y,
    S_DIV_Z,
    S_DONE
  } state_e;

  // |FIXED_MIN| = 2^(W-1) still fits as an unsigned W-bit value
  function automatic logic [FIXED_WIDTH-1:0] fixed_mag(
    input fixed_t v
  );
    logic [FIXED_WIDTH-1:0] u;
    u = v;
    return u[FIXED_WIDTH-1] ? (~u + 1'b1) : u;
  endfunction

endpackage

// File: rtl/div_fixed_iter.sv
// Unsigned restoring divider core, IPC quotient bits per clock.
// start reloads operands even while busy; quot_o is valid when done_o.
module div_fixed_iter #(
  parameter int N   = 48,
  parameter int D   = 33,
  parameter int IPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [D-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] quot_o,
  output logic [D-1:0] rem_o
);

  localparam int ITERS = N / IPC;
  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  logic [N-1:0]  quo_q, quo_d;
  logic [D-1:0]  rem_q, rem_d;
  logic [D-1:0]  dvs_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [D:0]    trial;

  // quo_q shifts dividend bits out the top and quotient bits in
  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    trial = '0;
    for (int i = 0; i < IPC; i++) begin
      trial = {rem_d, quo_d[N-1]};
      quo_d = {quo_d[N-2:0], 1'b0};
      if (trial >= {1'b0, dvs_q}) begin
        trial    = trial - {1'b0, dvs_q};
        quo_d[0] = 1'b1;
      end
      rem_d = trial[D-1:0];
    end
  end

  assign done_o = busy_q && (cnt_q == LAST);
  assign busy_o = busy_q;
  assign quot_o = quo_d;
  assign rem_o  = rem_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/div_vec3f.sv
// Multi-cycle signed fixed-point vec3 / scalar divide, one shared core.
// Define DIV_VEC3F_SAT_EN for saturating overflow and divide-by-zero.
module div_vec3f
  import div_vec3f_pkg::*;
#(
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  vec3_t  din_a,
  input  fixed_t din_b,
  input  logic   din_valid,
  output logic   din_ready,
  output vec3_t  dout,
  output logic   dout_div0,
  output logic   dout_valid,
  input  logic   dout_ready
);

  localparam int W = FIXED_WIDTH;
  localparam int F = FIXED_FRAC;
  localparam int N = W + F;
  localparam int D = W + 1;

  localparam logic [N-1:0] POS_LIM =
    {{F{1'b0}}, 1'b0, {(W-1){1'b1}}};
  localparam logic [N-1:0] NEG_LIM =
    {{F{1'b0}}, 1'b1, {(W-1){1'b0}}};

  state_e state_q;
  vec3_t  a_q;
  fixed_t b_q;
  logic   div0_q;
  vec3_t  dout_q;
  logic   dout_div0_q;
  logic   dout_valid_q;

  fixed_t       cur_a, nxt_a, res;
  logic         neg;
  logic [W-1:0] mag_lo;
  logic         core_start, core_done;
  logic [N-1:0] core_dvd, core_quot;
  logic [D-1:0] core_dvs;
  logic         core_busy_unused;
  logic [D-1:0] core_rem_unused;

  // cur_a: component finishing now; nxt_a: operand for next start
  always_comb begin
    cur_a = a_q.x;
    nxt_a = a_q.x;
    case (state_q)
      S_DIV_X: begin cur_a = a_q.x; nxt_a = a_q.y; end
      S_DIV_Y: begin cur_a = a_q.y; nxt_a = a_q.z; end
      S_DIV_Z: begin cur_a = a_q.z; nxt_a = a_q.z; end
      default: begin cur_a = a_q.x; nxt_a = a_q.x; end
    endcase
  end

  assign core_start = (state_q == S_LOAD) ||
    (core_done && (state_q == S_DIV_X ||
                   state_q == S_DIV_Y));
  assign core_dvd = {fixed_mag(nxt_a), {F{1'b0}}};
  assign core_dvs = {1'b0, fixed_mag(b_q)};
  assign neg      = cur_a[W-1] ^ b_q[W-1];

  div_fixed_iter #(
    .N   (N),
    .D   (D),
    .IPC (ITER_PER_CYCLE)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .start_i    (core_start),
    .dividend_i (core_dvd),
    .divisor_i  (core_dvs),
    .busy_o     (core_busy_unused),
    .done_o     (core_done),
    .quot_o     (core_quot),
    .rem_o      (core_rem_unused)
  );

  always_comb begin
    mag_lo = core_quot[W-1:0];
    res    = neg ? (~mag_lo + 1'b1) : mag_lo;
`ifdef DIV_VEC3F_SAT_EN
    if (div0_q)
      res = (cur_a == '0) ? '0 :
            (cur_a[W-1] ? FIXED_MIN : FIXED_MAX);
    else if (!neg && core_quot > POS_LIM)
      res = FIXED_MAX;
    else if (neg && core_quot > NEG_LIM)
      res = FIXED_MIN;
`else
    if (div0_q) res = '0;
`endif
  end

`ifndef DIV_VEC3F_SAT_EN
  logic unused_nosat;
  assign unused_nosat =
    ^{core_quot[N-1:W], cur_a[W-2:0], POS_LIM, NEG_LIM};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      div0_q       <= 1'b0;
      dout_q       <= '0;
      dout_div0_q  <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (din_valid) begin
          a_q     <= din_a;
          b_q     <= din_b;
          div0_q  <= (din_b == '0);
          state_q <= S_LOAD;
        end
        S_LOAD: state_q <= S_DIV_X;
        S_DIV_X: if (core_done) begin
          dout_q.x <= res;
          state_q  <= S_DIV_Y;
        end
        S_DIV_Y: if (core_done) begin
          dout_q.y <= res;
          state_q  <= S_DIV_Z;
        end
        S_DIV_Z: if (core_done) begin
          dout_q.z     <= res;
          dout_div0_q  <= div0_q;
          dout_valid_q <= 1'b1;
          state_q      <= S_DONE;
        end
        S_DONE: if (dout_ready) begin
          dout_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign din_ready  = (state_q == S_IDLE) && !rst;
  assign dout       = dout_q;
  assign dout_div0  = dout_div0_q;
  assign dout_valid = dout_valid_q;

endmodule
